rob_multi_commit: RTL and testbench
===================================

# rob_multi_commit

Parametrised reorder buffer with configurable depth and commit width (1 or 2 per cycle) for the out-of-order core. Sits between the decoder (allocation, operand lookup), the two result buses (ALU CDB, load/store CDB) and the architectural side (register file, store queue, branch predictor, fetch redirect). Compared with the single-commit buffer it replaces, it adds:
- count-based full/empty tracking;
- CDB-to-query bypass;
- dual in-order commit;
- a self-contained squash on a misprediction.

## Interface
- DEPTH, 16, number of entries; power of two, 4..64; tags are 1..DEPTH, tag 0 means "none"
- TAG_W, 5, tag width; must satisfy 2^TAG_W > DEPTH
- COMMIT_W, 2, maximum commits per cycle; 1 or 2
- DATA_W, 32, data/PC width
- REG_W, 5, architectural register index width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_ena  in  1  global stall when 0; no state change, outputs hold, except the pulse outputs, which fall to 0
- in_alloc_ena  in  1  allocate one entry this cycle
- in_alloc_kind  in  2  0 = reg write, 1 = branch, 2 = jalr, 3 = store
- in_alloc_dest, in_alloc_pc, in_alloc_pred_taken  in  REG_W/DATA_W/1  entry payload
- out_alloc_tag  out  TAG_W  tag the next allocation will receive (combinational)
- out_alloc_ok  out  1  at least 2 free entries (combinational, from registered count)
- in_cdb_tag, in_cdb_value, in_cdb_jump, in_cdb_jump_addr  in  TAG_W/DATA_W/1/DATA_W  ALU result; tag 0 = idle
- in_ls_tag, in_ls_value  in  TAG_W/DATA_W  load result; tag 0 = idle
- in_q_tag[1:2]  in  TAG_W  operand query tags
- out_q_ready[1:2], out_q_value[1:2]  out  1/DATA_W  query results (combinational)
- out_wr_reg[0:COMMIT_W-1], out_wr_tag[..], out_wr_value[..]  out  REG_W/TAG_W/DATA_W  register commits; reg 0 = none
- out_store_tag  out  TAG_W  committed store tag; 0 = none
- out_bp_ena, out_bp_pc, out_bp_taken  out  1/DATA_W/1  predictor update
- out_misbranch, out_redirect_pc  out  1/DATA_W  fetch redirect and pipeline squash
- out_count  out  TAG_W+1  occupied entries

## Operation
- **Storage.** Circular buffer with head, tail and count, all registered.
  - Empty when count == 0; full when count == DEPTH.
  - Pointers wrap DEPTH → 1.
- **Allocation.** If in_alloc_ena is high and in_ena is high, the entry at tail takes:
  - the payload;
  - ready = 0, jump = 0.
  - tail advances and count increments.
  - in_alloc_ena while count == DEPTH is ignored.
- **Writeback.**
  - A nonzero in_cdb_tag sets data, ready, jump and jump_addr.
  - A nonzero in_ls_tag sets data and ready.
  - Both buses may target distinct tags in the same cycle. Equal tags are illegal.
- **Query.**
  - Tag 0 returns ready 0, value 0.
  - Priority: in_cdb_tag match, then in_ls_tag match (ready 1, bus value), then stored entry.
- **Commit.**
  - Slot 0 commits head if count ≥ 1 and the entry is ready.
  - Slot 1 (COMMIT_W = 2) commits head+1 only if all of the following hold:
    - slot 0 committed;
    - count ≥ 2;
    - head+1 is ready;
    - head is kind 0.
  - Branch, jalr and store therefore always terminate the commit group. At most one store and one predictor update per cycle.
- **Commit action by kind.**
  - Kind 0: out_wr_* = dest/tag/data.
  - Kind 3: out_store_tag = tag.
  - Kind 1:
    - out_bp_ena = 1, out_bp_pc = pc, out_bp_taken = jump.
    - If jump ≠ pred_taken: out_misbranch = 1, out_redirect_pc = jump_addr.
  - Kind 2:
    - Register write of the link value.
    - bp update with taken = 1.
    - Unconditional misbranch with redirect = jump_addr.
- **Squash.**
  - The commit that raises out_misbranch also sets count ← 0 and head ← tail ← slot after the committed entry.
  - Allocation and writeback in that cycle are discarded.
- **Unused outputs.** Commit outputs not driven in a cycle are 0.

## Timing
- **Reset (rst_n = 0 at edge).**
  - Registers: head = tail = 1, count = 0, all ready bits 0.
  - Outputs: all registered outputs 0.
  - Reset overrides in_ena.
- **Output registration.** All commit outputs are registered pulses lasting one cycle.
- **Latency.** A writeback at edge N makes the entry committable. It appears on the commit outputs after edge N+1. Commit reads registered ready only, so there is no same-edge writeback-to-commit path.
- **Allocation and commit.**
  - Same-cycle alloc and commit: count += 1 − commits.
  - out_alloc_ok ignores commits in the same cycle.
- **Wrap.** Slot 1 at head = DEPTH uses entry 1.
- **Stall.** in_ena = 0 mid-stream freezes all state. Pulse outputs drop to 0.

## Test plan
- **Reset then single alloc.** Reset; alloc kind 0, dest 5, CDB tag 1 value 0xAB → out_wr_reg[0] = 5, value 0xAB exactly 2 cycles after the CDB cycle; out_count returns to 0.
- **Dual commit.** DEPTH = 4. Fill 4 kind-0 entries; check out_alloc_ok = 0 at count 3 and at count 4. Write back tags 2, 1, 4, 3 out of order → commits (1,2) then (3,4) on consecutive cycles. Wrap: allocate 2 more and confirm they get tags 1, 2.
- **Branch terminates group.** Sequence branch (pred 0, resolves taken, addr 0x100), then kind 0 → out_misbranch = 1 with redirect 0x100 alone in its cycle. The kind-0 entry is squashed and out_count = 0. out_bp_taken = 1.
- **Bypass.** Query tag 3 while the CDB writes tag 3 value 7 → out_q_ready1 = 1, out_q_value1 = 7 in the same cycle. Tag 0 query → ready 0.
- **Store then register.** Commits in separate cycles; out_store_tag equals the store's tag for exactly 1 cycle.
- **Reset mid-operation.** Assert rst_n = 0 with 3 pending entries → next cycle out_count = 0 and out_alloc_tag = 1. No commit pulses follow.

Source files
------------

// File: rtl/rob_multi_commit_if.sv
// Bus bundle between the reorder buffer and the decoder / result buses / architectural side.
// The parameters must match the ones given to rob_multi_commit.
interface rob_multi_commit_if #(
  parameter int TAG_W    = 5,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5
) ();
  logic                                in_ena;
  logic                                in_alloc_ena;
  logic [1:0]                          in_alloc_kind;
  logic [REG_W-1:0]                    in_alloc_dest;
  logic [DATA_W-1:0]                   in_alloc_pc;
  logic                                in_alloc_pred_taken;
  logic [TAG_W-1:0]                    out_alloc_tag;
  logic                                out_alloc_ok;
  logic [TAG_W-1:0]                    in_cdb_tag;
  logic [DATA_W-1:0]                   in_cdb_value;
  logic                                in_cdb_jump;
  logic [DATA_W-1:0]                   in_cdb_jump_addr;
  logic [TAG_W-1:0]                    in_ls_tag;
  logic [DATA_W-1:0]                   in_ls_value;
  logic [TAG_W-1:0]                    in_q_tag1, in_q_tag2;
  logic                                out_q_ready1, out_q_ready2;
  logic [DATA_W-1:0]                   out_q_value1, out_q_value2;
  logic [COMMIT_W-1:0][REG_W-1:0]      out_wr_reg;
  logic [COMMIT_W-1:0][TAG_W-1:0]      out_wr_tag;
  logic [COMMIT_W-1:0][DATA_W-1:0]     out_wr_value;
  logic [TAG_W-1:0]                    out_store_tag;
  logic                                out_bp_ena;
  logic [DATA_W-1:0]                   out_bp_pc;
  logic                                out_bp_taken;
  logic                                out_misbranch;
  logic [DATA_W-1:0]                   out_redirect_pc;
  logic [TAG_W:0]                      out_count;

  modport master (
    output in_ena, in_alloc_ena, in_alloc_kind, in_alloc_dest, in_alloc_pc, in_alloc_pred_taken,
           in_cdb_tag, in_cdb_value, in_cdb_jump, in_cdb_jump_addr, in_ls_tag, in_ls_value,
           in_q_tag1, in_q_tag2,
    input  out_alloc_tag, out_alloc_ok, out_q_ready1, out_q_ready2, out_q_value1, out_q_value2,
           out_wr_reg, out_wr_tag, out_wr_value, out_store_tag, out_bp_ena, out_bp_pc,
           out_bp_taken, out_misbranch, out_redirect_pc, out_count
  );
  modport slave (
    input  in_ena, in_alloc_ena, in_alloc_kind, in_alloc_dest, in_alloc_pc, in_alloc_pred_taken,
           in_cdb_tag, in_cdb_value, in_cdb_jump, in_cdb_jump_addr, in_ls_tag, in_ls_value,
           in_q_tag1, in_q_tag2,
    output out_alloc_tag, out_alloc_ok, out_q_ready1, out_q_ready2, out_q_value1, out_q_value2,
           out_wr_reg, out_wr_tag, out_wr_value, out_store_tag, out_bp_ena, out_bp_pc,
           out_bp_taken, out_misbranch, out_redirect_pc, out_count
  );
endinterface

// File: rtl/rob_multi_commit.sv
// Reorder buffer with 1- or 2-wide in-order commit, CDB/LS query bypass and self-squash on misprediction.
// Entries live at slots 1..DEPTH; tag == slot index, tag 0 means "none".
module rob_multi_commit #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = 5,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5
) (
  input logic              clk,
  input logic              rst_n,
  rob_multi_commit_if.slave rob
);
  localparam int CW = TAG_W + 1;
  localparam logic [1:0] K_REG = 2'd0, K_BR = 2'd1, K_JALR = 2'd2, K_ST = 2'd3;

  function automatic logic [TAG_W-1:0] nxt(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(DEPTH)) ? TAG_W'(1) : p + TAG_W'(1);
  endfunction

  logic [1:0]        r_kind  [0:DEPTH];
  logic [REG_W-1:0]  r_dest  [0:DEPTH];
  logic [DATA_W-1:0] r_pc    [0:DEPTH];
  logic [DATA_W-1:0] r_data  [0:DEPTH];
  logic [DATA_W-1:0] r_jaddr [0:DEPTH];
  logic [DEPTH:0]    r_ready, r_jump, r_pred;
  logic [TAG_W-1:0]  r_head, r_tail;
  logic [CW-1:0]     r_count;

  logic [COMMIT_W-1:0][REG_W-1:0]  r_wr_reg,   w_wr_reg;
  logic [COMMIT_W-1:0][TAG_W-1:0]  r_wr_tag,   w_wr_tag;
  logic [COMMIT_W-1:0][DATA_W-1:0] r_wr_value, w_wr_value;
  logic [TAG_W-1:0]  r_store_tag, w_store_tag;
  logic              r_bp_ena, w_bp_ena, r_bp_taken, w_bp_taken, r_mis, w_mis;
  logic [DATA_W-1:0] r_bp_pc, w_bp_pc, r_redirect, w_redirect;

  logic [COMMIT_W-1:0][TAG_W-1:0] w_ent;
  logic [COMMIT_W-1:0]            w_cm;
  logic [1:0]                     w_ncommit;
  logic [TAG_W-1:0]               w_head_nxt;
  logic                           w_alloc;

  assign w_alloc  = rob.in_alloc_ena && (r_count != CW'(DEPTH));
  assign w_ent[0] = r_head;
  assign w_cm[0]  = (r_count != '0) && r_ready[r_head];

  // Second slot only behind a plain register write, so branch/jalr/store always end the group.
  generate if (COMMIT_W == 2) begin : g_slot1
    logic [TAG_W-1:0] w_h1;
    assign w_h1     = nxt(r_head);
    assign w_ent[1] = w_h1;
    assign w_cm[1]  = w_cm[0] && (r_count >= CW'(2)) && r_ready[w_h1] && (r_kind[r_head] == K_REG);
  end endgenerate

  always_comb begin
    w_wr_reg = '0; w_wr_tag = '0; w_wr_value = '0; w_store_tag = '0;
    w_bp_ena = 1'b0; w_bp_pc = '0; w_bp_taken = 1'b0; w_mis = 1'b0; w_redirect = '0;
    w_ncommit = '0; w_head_nxt = r_head;
    for (int s = 0; s < COMMIT_W; s++) begin
      if (w_cm[s]) begin
        w_ncommit  = w_ncommit + 2'd1;
        w_head_nxt = nxt(w_head_nxt);
        case (r_kind[w_ent[s]])
          K_REG: begin
            w_wr_reg[s] = r_dest[w_ent[s]]; w_wr_tag[s] = w_ent[s]; w_wr_value[s] = r_data[w_ent[s]];
          end
          K_ST: w_store_tag = w_ent[s];
          K_BR: begin
            w_bp_ena = 1'b1; w_bp_pc = r_pc[w_ent[s]]; w_bp_taken = r_jump[w_ent[s]];
            if (r_jump[w_ent[s]] != r_pred[w_ent[s]]) begin
              w_mis = 1'b1; w_redirect = r_jaddr[w_ent[s]];
            end
          end
          default: begin
            w_wr_reg[s] = r_dest[w_ent[s]]; w_wr_tag[s] = w_ent[s]; w_wr_value[s] = r_data[w_ent[s]];
            w_bp_ena = 1'b1; w_bp_pc = r_pc[w_ent[s]]; w_bp_taken = 1'b1;
            w_mis = 1'b1; w_redirect = r_jaddr[w_ent[s]];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= TAG_W'(1); r_tail <= TAG_W'(1); r_count <= '0; r_ready <= '0;
      r_wr_reg <= '0; r_wr_tag <= '0; r_wr_value <= '0; r_store_tag <= '0;
      r_bp_ena <= 1'b0; r_bp_pc <= '0; r_bp_taken <= 1'b0; r_mis <= 1'b0; r_redirect <= '0;
    end else if (rob.in_ena) begin
      r_wr_reg <= w_wr_reg; r_wr_tag <= w_wr_tag; r_wr_value <= w_wr_value; r_store_tag <= w_store_tag;
      r_bp_ena <= w_bp_ena; r_bp_pc <= w_bp_pc; r_bp_taken <= w_bp_taken;
      r_mis <= w_mis; r_redirect <= w_redirect;
      r_head <= w_head_nxt;
      if (w_mis) begin
        r_tail <= w_head_nxt; r_count <= '0; r_ready <= '0;
      end else begin
        if (w_alloc) r_tail <= nxt(r_tail);
        r_count <= r_count + CW'(w_alloc) - CW'(w_ncommit);
        for (int i = 1; i <= DEPTH; i++) begin
          if (w_alloc && r_tail == TAG_W'(i)) r_ready[i] <= 1'b0;
          if (rob.in_cdb_tag == TAG_W'(i) || rob.in_ls_tag == TAG_W'(i)) r_ready[i] <= 1'b1;
        end
      end
    end else begin
      // Stalled: state holds, commit pulses fall.
      r_wr_reg <= '0; r_wr_tag <= '0; r_wr_value <= '0; r_store_tag <= '0;
      r_bp_ena <= 1'b0; r_bp_pc <= '0; r_bp_taken <= 1'b0; r_mis <= 1'b0; r_redirect <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && rob.in_ena && !w_mis) begin
      for (int i = 1; i <= DEPTH; i++) begin
        if (w_alloc && r_tail == TAG_W'(i)) begin
          r_kind[i] <= rob.in_alloc_kind; r_dest[i] <= rob.in_alloc_dest;
          r_pc[i] <= rob.in_alloc_pc; r_pred[i] <= rob.in_alloc_pred_taken; r_jump[i] <= 1'b0;
        end
        if (rob.in_cdb_tag == TAG_W'(i)) begin
          r_data[i] <= rob.in_cdb_value; r_jump[i] <= rob.in_cdb_jump; r_jaddr[i] <= rob.in_cdb_jump_addr;
        end
        if (rob.in_ls_tag == TAG_W'(i)) r_data[i] <= rob.in_ls_value;
      end
    end
  end

  logic [TAG_W-1:0]  w_qt [2];
  logic              w_qr [2];
  logic [DATA_W-1:0] w_qv [2];
  assign w_qt[0] = rob.in_q_tag1;
  assign w_qt[1] = rob.in_q_tag2;

  // Results on the buses this cycle win over the stored copy.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      w_qr[q] = 1'b0; w_qv[q] = '0;
      if (w_qt[q] != '0) begin
        if (rob.in_cdb_tag == w_qt[q])     begin w_qr[q] = 1'b1; w_qv[q] = rob.in_cdb_value; end
        else if (rob.in_ls_tag == w_qt[q]) begin w_qr[q] = 1'b1; w_qv[q] = rob.in_ls_value; end
        else begin w_qr[q] = r_ready[w_qt[q]]; w_qv[q] = r_data[w_qt[q]]; end
      end
    end
  end

  assign rob.out_q_ready1    = w_qr[0];
  assign rob.out_q_value1    = w_qv[0];
  assign rob.out_q_ready2    = w_qr[1];
  assign rob.out_q_value2    = w_qv[1];
  assign rob.out_alloc_tag   = r_tail;
  assign rob.out_alloc_ok    = (CW'(DEPTH) - r_count) >= CW'(2);
  assign rob.out_count       = r_count;
  assign rob.out_wr_reg      = r_wr_reg;
  assign rob.out_wr_tag      = r_wr_tag;
  assign rob.out_wr_value    = r_wr_value;
  assign rob.out_store_tag   = r_store_tag;
  assign rob.out_bp_ena      = r_bp_ena;
  assign rob.out_bp_pc       = r_bp_pc;
  assign rob.out_bp_taken    = r_bp_taken;
  assign rob.out_misbranch   = r_mis;
  assign rob.out_redirect_pc = r_redirect;
endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit at DEPTH=4, dual commit; expected values are hand-derived.
module tb_rob_multi_commit;
  localparam int DEPTH = 4, TAG_W = 3, COMMIT_W = 2, DATA_W = 32, REG_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  rob_multi_commit_if #(.TAG_W(TAG_W), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();
  rob_multi_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W), .REG_W(REG_W))
    dut (.clk(clk), .rst_n(rst_n), .rob(bus));

  always #5 clk = ~clk;

  task automatic step(); @(posedge clk); #1; endtask

  task automatic idle();
    bus.in_ena = 1'b1; bus.in_alloc_ena = 1'b0; bus.in_alloc_kind = 2'd0; bus.in_alloc_dest = '0;
    bus.in_alloc_pc = '0; bus.in_alloc_pred_taken = 1'b0;
    bus.in_cdb_tag = '0; bus.in_cdb_value = '0; bus.in_cdb_jump = 1'b0; bus.in_cdb_jump_addr = '0;
    bus.in_ls_tag = '0; bus.in_ls_value = '0; bus.in_q_tag1 = '0; bus.in_q_tag2 = '0;
  endtask

  task automatic do_reset(); idle(); rst_n = 1'b0; step(); rst_n = 1'b1; endtask

  task automatic alloc(input logic [1:0] k, input logic [4:0] d, input logic [31:0] pc, input logic p);
    bus.in_alloc_kind = k; bus.in_alloc_dest = d; bus.in_alloc_pc = pc; bus.in_alloc_pred_taken = p;
    bus.in_alloc_ena = 1'b1; step(); bus.in_alloc_ena = 1'b0;
  endtask

  task automatic clear_bus();
    bus.in_cdb_tag = '0; bus.in_cdb_value = '0; bus.in_cdb_jump = 1'b0; bus.in_cdb_jump_addr = '0;
    bus.in_ls_tag = '0; bus.in_ls_value = '0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    n_checks++; if (bus.out_count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", bus.out_count); end
    n_checks++; if (bus.out_alloc_tag !== 3'd1) begin n_fail++; $display("FAIL rst_alloc_tag: got %0d expected 1", bus.out_alloc_tag); end
    n_checks++; if (bus.out_alloc_ok !== 1'b1) begin n_fail++; $display("FAIL rst_alloc_ok: got %0b expected 1", bus.out_alloc_ok); end
    n_checks++; if (bus.out_misbranch !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %0b expected 0", bus.out_misbranch); end
    n_checks++; if (bus.out_wr_reg[0] !== 5'd0) begin n_fail++; $display("FAIL rst_wr_reg: got %0d expected 0", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_store_tag !== 3'd0) begin n_fail++; $display("FAIL rst_store: got %0d expected 0", bus.out_store_tag); end
  endtask

  task automatic test_single();
    do_reset();
    alloc(2'd0, 5'd5, 32'h40, 1'b0);
    n_checks++; if (bus.out_count !== 4'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", bus.out_count); end
    n_checks++; if (bus.out_alloc_tag !== 3'd2) begin n_fail++; $display("FAIL single_tag: got %0d expected 2", bus.out_alloc_tag); end
    bus.in_cdb_tag = 3'd1; bus.in_cdb_value = 32'hAB; step(); clear_bus();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd0) begin n_fail++; $display("FAIL single_early: got %0d expected 0", bus.out_wr_reg[0]); end
    step();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd5) begin n_fail++; $display("FAIL single_reg: got %0d expected 5", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_wr_tag[0] !== 3'd1) begin n_fail++; $display("FAIL single_wtag: got %0d expected 1", bus.out_wr_tag[0]); end
    n_checks++; if (bus.out_wr_value[0] !== 32'hAB) begin n_fail++; $display("FAIL single_val: got %0h expected ab", bus.out_wr_value[0]); end
    n_checks++; if (bus.out_wr_reg[1] !== 5'd0) begin n_fail++; $display("FAIL single_slot1: got %0d expected 0", bus.out_wr_reg[1]); end
    n_checks++; if (bus.out_count !== 4'd0) begin n_fail++; $display("FAIL single_count0: got %0d expected 0", bus.out_count); end
    step();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd0) begin n_fail++; $display("FAIL single_pulse: got %0d expected 0", bus.out_wr_reg[0]); end
  endtask

  task automatic test_dual();
    do_reset();
    n_checks++; if (bus.out_alloc_ok !== 1'b1) begin n_fail++; $display("FAIL dual_ok0: got %0b expected 1", bus.out_alloc_ok); end
    alloc(2'd0, 5'd10, 32'h0, 1'b0); alloc(2'd0, 5'd11, 32'h0, 1'b0);
    n_checks++; if (bus.out_alloc_ok !== 1'b1) begin n_fail++; $display("FAIL dual_ok2: got %0b expected 1", bus.out_alloc_ok); end
    alloc(2'd0, 5'd12, 32'h0, 1'b0);
    n_checks++; if (bus.out_alloc_ok !== 1'b0) begin n_fail++; $display("FAIL dual_ok3: got %0b expected 0", bus.out_alloc_ok); end
    alloc(2'd0, 5'd13, 32'h0, 1'b0);
    n_checks++; if (bus.out_alloc_ok !== 1'b0) begin n_fail++; $display("FAIL dual_ok4: got %0b expected 0", bus.out_alloc_ok); end
    n_checks++; if (bus.out_count !== 4'd4) begin n_fail++; $display("FAIL dual_full: got %0d expected 4", bus.out_count); end
    alloc(2'd0, 5'd31, 32'h0, 1'b0);
    n_checks++; if (bus.out_count !== 4'd4) begin n_fail++; $display("FAIL dual_ovf_count: got %0d expected 4", bus.out_count); end
    n_checks++; if (bus.out_alloc_tag !== 3'd1) begin n_fail++; $display("FAIL dual_ovf_tag: got %0d expected 1", bus.out_alloc_tag); end
    bus.in_cdb_tag = 3'd2; bus.in_cdb_value = 32'h22; step();
    bus.in_cdb_tag = 3'd1; bus.in_cdb_value = 32'h11; bus.in_ls_tag = 3'd4; bus.in_ls_value = 32'h44; step();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd0) begin n_fail++; $display("FAIL dual_none: got %0d expected 0", bus.out_wr_reg[0]); end
    clear_bus(); bus.in_cdb_tag = 3'd3; bus.in_cdb_value = 32'h33; step(); clear_bus();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd10) begin n_fail++; $display("FAIL dual_a0: got %0d expected 10", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_wr_reg[1] !== 5'd11) begin n_fail++; $display("FAIL dual_a1: got %0d expected 11", bus.out_wr_reg[1]); end
    n_checks++; if (bus.out_wr_tag[1] !== 3'd2) begin n_fail++; $display("FAIL dual_a1tag: got %0d expected 2", bus.out_wr_tag[1]); end
    n_checks++; if (bus.out_wr_value[1] !== 32'h22) begin n_fail++; $display("FAIL dual_a1val: got %0h expected 22", bus.out_wr_value[1]); end
    n_checks++; if (bus.out_count !== 4'd2) begin n_fail++; $display("FAIL dual_cnt2: got %0d expected 2", bus.out_count); end
    step();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd12) begin n_fail++; $display("FAIL dual_b0: got %0d expected 12", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_wr_value[0] !== 32'h33) begin n_fail++; $display("FAIL dual_b0val: got %0h expected 33", bus.out_wr_value[0]); end
    n_checks++; if (bus.out_wr_reg[1] !== 5'd13) begin n_fail++; $display("FAIL dual_b1: got %0d expected 13", bus.out_wr_reg[1]); end
    n_checks++; if (bus.out_wr_value[1] !== 32'h44) begin n_fail++; $display("FAIL dual_b1val: got %0h expected 44", bus.out_wr_value[1]); end
    n_checks++; if (bus.out_count !== 4'd0) begin n_fail++; $display("FAIL dual_cnt0: got %0d expected 0", bus.out_count); end
    n_checks++; if (bus.out_alloc_tag !== 3'd1) begin n_fail++; $display("FAIL dual_wrap1: got %0d expected 1", bus.out_alloc_tag); end
    alloc(2'd0, 5'd1, 32'h0, 1'b0);
    n_checks++; if (bus.out_alloc_tag !== 3'd2) begin n_fail++; $display("FAIL dual_wrap2: got %0d expected 2", bus.out_alloc_tag); end
    alloc(2'd0, 5'd2, 32'h0, 1'b0);
    n_checks++; if (bus.out_alloc_tag !== 3'd3) begin n_fail++; $display("FAIL dual_wrap3: got %0d expected 3", bus.out_alloc_tag); end
  endtask

  task automatic test_wrap_slot1();
    do_reset();
    bus.in_alloc_kind = 2'd0; bus.in_alloc_ena = 1'b1; bus.in_alloc_dest = 5'd1; step();
    bus.in_alloc_dest = 5'd2; bus.in_cdb_tag = 3'd1; bus.in_cdb_value = 32'h1; step();
    bus.in_alloc_dest = 5'd3; bus.in_cdb_tag = 3'd2; bus.in_cdb_value = 32'h2; step();
    bus.in_alloc_ena = 1'b0; bus.in_cdb_tag = 3'd3; bus.in_cdb_value = 32'h3; step();
    clear_bus(); step();
    n_checks++; if (bus.out_count !== 4'd0) begin n_fail++; $display("FAIL wrap_drain: got %0d expected 0", bus.out_count); end
    n_checks++; if (bus.out_alloc_tag !== 3'd4) begin n_fail++; $display("FAIL wrap_tail: got %0d expected 4", bus.out_alloc_tag); end
    alloc(2'd0, 5'd7, 32'h0, 1'b0); alloc(2'd0, 5'd8, 32'h0, 1'b0);
    n_checks++; if (bus.out_alloc_tag !== 3'd2) begin n_fail++; $display("FAIL wrap_tail2: got %0d expected 2", bus.out_alloc_tag); end
    bus.in_cdb_tag = 3'd4; bus.in_cdb_value = 32'h4; bus.in_ls_tag = 3'd1; bus.in_ls_value = 32'h5; step();
    clear_bus(); step();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd7) begin n_fail++; $display("FAIL wrap_s0: got %0d expected 7", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_wr_tag[0] !== 3'd4) begin n_fail++; $display("FAIL wrap_s0tag: got %0d expected 4", bus.out_wr_tag[0]); end
    n_checks++; if (bus.out_wr_reg[1] !== 5'd8) begin n_fail++; $display("FAIL wrap_s1: got %0d expected 8", bus.out_wr_reg[1]); end
    n_checks++; if (bus.out_wr_tag[1] !== 3'd1) begin n_fail++; $display("FAIL wrap_s1tag: got %0d expected 1", bus.out_wr_tag[1]); end
    n_checks++; if (bus.out_wr_value[1] !== 32'h5) begin n_fail++; $display("FAIL wrap_s1val: got %0h expected 5", bus.out_wr_value[1]); end
  endtask

  task automatic test_branch_mis();
    do_reset();
    alloc(2'd1, 5'd0, 32'h80, 1'b0); alloc(2'd0, 5'd9, 32'h0, 1'b0);
    bus.in_cdb_tag = 3'd1; bus.in_cdb_jump = 1'b1; bus.in_cdb_jump_addr = 32'h100; step();
    clear_bus(); bus.in_cdb_tag = 3'd2; bus.in_cdb_value = 32'h99; step(); clear_bus();
    n_checks++; if (bus.out_misbranch !== 1'b1) begin n_fail++; $display("FAIL br_mis: got %0b expected 1", bus.out_misbranch); end
    n_checks++; if (bus.out_redirect_pc !== 32'h100) begin n_fail++; $display("FAIL br_redir: got %0h expected 100", bus.out_redirect_pc); end
    n_checks++; if (bus.out_bp_ena !== 1'b1) begin n_fail++; $display("FAIL br_bpena: got %0b expected 1", bus.out_bp_ena); end
    n_checks++; if (bus.out_bp_pc !== 32'h80) begin n_fail++; $display("FAIL br_bppc: got %0h expected 80", bus.out_bp_pc); end
    n_checks++; if (bus.out_bp_taken !== 1'b1) begin n_fail++; $display("FAIL br_taken: got %0b expected 1", bus.out_bp_taken); end
    n_checks++; if (bus.out_wr_reg[1] !== 5'd0) begin n_fail++; $display("FAIL br_alone: got %0d expected 0", bus.out_wr_reg[1]); end
    n_checks++; if (bus.out_count !== 4'd0) begin n_fail++; $display("FAIL br_squash: got %0d expected 0", bus.out_count); end
    n_checks++; if (bus.out_alloc_tag !== 3'd2) begin n_fail++; $display("FAIL br_tail: got %0d expected 2", bus.out_alloc_tag); end
    step();
    n_checks++; if (bus.out_misbranch !== 1'b0) begin n_fail++; $display("FAIL br_pulse: got %0b expected 0", bus.out_misbranch); end
    n_checks++; if (bus.out_wr_reg[0] !== 5'd0) begin n_fail++; $display("FAIL br_dead: got %0d expected 0", bus.out_wr_reg[0]); end
  endtask

  task automatic test_branch_ok();
    do_reset();
    alloc(2'd0, 5'd3, 32'h0, 1'b0); alloc(2'd1, 5'd0, 32'h44, 1'b1);
    bus.in_cdb_tag = 3'd2; bus.in_cdb_jump = 1'b1; bus.in_cdb_jump_addr = 32'h50;
    bus.in_ls_tag = 3'd1; bus.in_ls_value = 32'h1; step(); clear_bus(); step();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd3) begin n_fail++; $display("FAIL bok_reg: got %0d expected 3", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_wr_value[0] !== 32'h1) begin n_fail++; $display("FAIL bok_val: got %0h expected 1", bus.out_wr_value[0]); end
    n_checks++; if (bus.out_bp_ena !== 1'b1) begin n_fail++; $display("FAIL bok_bpena: got %0b expected 1", bus.out_bp_ena); end
    n_checks++; if (bus.out_bp_pc !== 32'h44) begin n_fail++; $display("FAIL bok_bppc: got %0h expected 44", bus.out_bp_pc); end
    n_checks++; if (bus.out_misbranch !== 1'b0) begin n_fail++; $display("FAIL bok_mis: got %0b expected 0", bus.out_misbranch); end
    n_checks++; if (bus.out_count !== 4'd0) begin n_fail++; $display("FAIL bok_count: got %0d expected 0", bus.out_count); end
    n_checks++; if (bus.out_alloc_tag !== 3'd3) begin n_fail++; $display("FAIL bok_tail: got %0d expected 3", bus.out_alloc_tag); end
  endtask

  task automatic test_jalr();
    do_reset();
    alloc(2'd2, 5'd1, 32'h200, 1'b1);
    bus.in_cdb_tag = 3'd1; bus.in_cdb_value = 32'h204; bus.in_cdb_jump = 1'b1; bus.in_cdb_jump_addr = 32'h300;
    step(); clear_bus(); step();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd1) begin n_fail++; $display("FAIL jalr_reg: got %0d expected 1", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_wr_value[0] !== 32'h204) begin n_fail++; $display("FAIL jalr_link: got %0h expected 204", bus.out_wr_value[0]); end
    n_checks++; if (bus.out_bp_ena !== 1'b1) begin n_fail++; $display("FAIL jalr_bp: got %0b expected 1", bus.out_bp_ena); end
    n_checks++; if (bus.out_bp_pc !== 32'h200) begin n_fail++; $display("FAIL jalr_bppc: got %0h expected 200", bus.out_bp_pc); end
    n_checks++; if (bus.out_misbranch !== 1'b1) begin n_fail++; $display("FAIL jalr_mis: got %0b expected 1", bus.out_misbranch); end
    n_checks++; if (bus.out_redirect_pc !== 32'h300) begin n_fail++; $display("FAIL jalr_redir: got %0h expected 300", bus.out_redirect_pc); end
    n_checks++; if (bus.out_alloc_tag !== 3'd2) begin n_fail++; $display("FAIL jalr_tail: got %0d expected 2", bus.out_alloc_tag); end
  endtask

  task automatic test_bypass();
    do_reset();
    alloc(2'd0, 5'd1, 32'h0, 1'b0); alloc(2'd0, 5'd2, 32'h0, 1'b0); alloc(2'd0, 5'd3, 32'h0, 1'b0);
    bus.in_cdb_tag = 3'd3; bus.in_cdb_value = 32'd7; bus.in_ls_tag = 3'd2; bus.in_ls_value = 32'h55;
    bus.in_q_tag1 = 3'd3; bus.in_q_tag2 = 3'd2; #1;
    n_checks++; if (bus.out_q_ready1 !== 1'b1) begin n_fail++; $display("FAIL byp_cdb_rdy: got %0b expected 1", bus.out_q_ready1); end
    n_checks++; if (bus.out_q_value1 !== 32'd7) begin n_fail++; $display("FAIL byp_cdb_val: got %0h expected 7", bus.out_q_value1); end
    n_checks++; if (bus.out_q_ready2 !== 1'b1) begin n_fail++; $display("FAIL byp_ls_rdy: got %0b expected 1", bus.out_q_ready2); end
    n_checks++; if (bus.out_q_value2 !== 32'h55) begin n_fail++; $display("FAIL byp_ls_val: got %0h expected 55", bus.out_q_value2); end
    bus.in_q_tag2 = 3'd0; #1;
    n_checks++; if (bus.out_q_ready2 !== 1'b0) begin n_fail++; $display("FAIL byp_t0_rdy: got %0b expected 0", bus.out_q_ready2); end
    n_checks++; if (bus.out_q_value2 !== 32'd0) begin n_fail++; $display("FAIL byp_t0_val: got %0h expected 0", bus.out_q_value2); end
    step(); clear_bus(); bus.in_q_tag1 = 3'd3; bus.in_q_tag2 = 3'd1; #1;
    n_checks++; if (bus.out_q_ready1 !== 1'b1) begin n_fail++; $display("FAIL byp_st_rdy: got %0b expected 1", bus.out_q_ready1); end
    n_checks++; if (bus.out_q_value1 !== 32'd7) begin n_fail++; $display("FAIL byp_st_val: got %0h expected 7", bus.out_q_value1); end
    n_checks++; if (bus.out_q_ready2 !== 1'b0) begin n_fail++; $display("FAIL byp_notrdy: got %0b expected 0", bus.out_q_ready2); end
    bus.in_q_tag1 = 3'd0; bus.in_q_tag2 = 3'd0;
  endtask

  task automatic test_store();
    do_reset();
    alloc(2'd3, 5'd0, 32'h0, 1'b0); alloc(2'd0, 5'd6, 32'h0, 1'b0);
    bus.in_cdb_tag = 3'd1; bus.in_ls_tag = 3'd2; bus.in_ls_value = 32'h66; step(); clear_bus(); step();
    n_checks++; if (bus.out_store_tag !== 3'd1) begin n_fail++; $display("FAIL st_tag: got %0d expected 1", bus.out_store_tag); end
    n_checks++; if (bus.out_wr_reg[0] !== 5'd0) begin n_fail++; $display("FAIL st_reg0: got %0d expected 0", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_wr_reg[1] !== 5'd0) begin n_fail++; $display("FAIL st_reg1: got %0d expected 0", bus.out_wr_reg[1]); end
    n_checks++; if (bus.out_count !== 4'd1) begin n_fail++; $display("FAIL st_count: got %0d expected 1", bus.out_count); end
    step();
    n_checks++; if (bus.out_store_tag !== 3'd0) begin n_fail++; $display("FAIL st_pulse: got %0d expected 0", bus.out_store_tag); end
    n_checks++; if (bus.out_wr_reg[0] !== 5'd6) begin n_fail++; $display("FAIL st_next: got %0d expected 6", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_wr_value[0] !== 32'h66) begin n_fail++; $display("FAIL st_nextval: got %0h expected 66", bus.out_wr_value[0]); end
  endtask

  task automatic test_stall();
    do_reset();
    alloc(2'd0, 5'd2, 32'h0, 1'b0);
    bus.in_cdb_tag = 3'd1; bus.in_cdb_value = 32'h12; step(); clear_bus();
    bus.in_ena = 1'b0; bus.in_alloc_ena = 1'b1; bus.in_alloc_dest = 5'd4; step();
    n_checks++; if (bus.out_count !== 4'd1) begin n_fail++; $display("FAIL stall_count: got %0d expected 1", bus.out_count); end
    n_checks++; if (bus.out_alloc_tag !== 3'd2) begin n_fail++; $display("FAIL stall_tail: got %0d expected 2", bus.out_alloc_tag); end
    n_checks++; if (bus.out_wr_reg[0] !== 5'd0) begin n_fail++; $display("FAIL stall_nocommit: got %0d expected 0", bus.out_wr_reg[0]); end
    step();
    n_checks++; if (bus.out_count !== 4'd1) begin n_fail++; $display("FAIL stall_hold: got %0d expected 1", bus.out_count); end
    bus.in_ena = 1'b1; bus.in_alloc_ena = 1'b0; step();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd2) begin n_fail++; $display("FAIL stall_resume: got %0d expected 2", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_wr_value[0] !== 32'h12) begin n_fail++; $display("FAIL stall_val: got %0h expected 12", bus.out_wr_value[0]); end
    bus.in_ena = 1'b0; step();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd0) begin n_fail++; $display("FAIL stall_drop: got %0d expected 0", bus.out_wr_reg[0]); end
    bus.in_ena = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc(2'd0, 5'd1, 32'h0, 1'b0); alloc(2'd0, 5'd2, 32'h0, 1'b0);
    bus.in_alloc_dest = 5'd3; bus.in_alloc_ena = 1'b1; bus.in_cdb_tag = 3'd1; bus.in_cdb_value = 32'h9; step();
    bus.in_alloc_ena = 1'b0; clear_bus();
    n_checks++; if (bus.out_count !== 4'd3) begin n_fail++; $display("FAIL rmid_pending: got %0d expected 3", bus.out_count); end
    rst_n = 1'b0; bus.in_ena = 1'b0; step();
    n_checks++; if (bus.out_count !== 4'd0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", bus.out_count); end
    n_checks++; if (bus.out_alloc_tag !== 3'd1) begin n_fail++; $display("FAIL rmid_tag: got %0d expected 1", bus.out_alloc_tag); end
    n_checks++; if (bus.out_wr_reg[0] !== 5'd0) begin n_fail++; $display("FAIL rmid_wr: got %0d expected 0", bus.out_wr_reg[0]); end
    rst_n = 1'b1; bus.in_ena = 1'b1; step();
    n_checks++; if (bus.out_wr_reg[0] !== 5'd0) begin n_fail++; $display("FAIL rmid_after: got %0d expected 0", bus.out_wr_reg[0]); end
    n_checks++; if (bus.out_count !== 4'd0) begin n_fail++; $display("FAIL rmid_after_cnt: got %0d expected 0", bus.out_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_wrap_slot1();
    test_branch_mis();
    test_branch_ok();
    test_jalr();
    test_bypass();
    test_store();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
